// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one single-port data memory
// between the CPU load/store path and a debug/loader port. Each transaction
// runs IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> RESP. The winner's fields
// are latched at grant time, so a requester may change them after the grant.
module dmem_arbiter #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 8,
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic              clock,
   input  logic              reset,
   // CPU port
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   // debug / loader port
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_ready,
   // data memory side
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   // status
   output logic              gnt_dbg,
   output logic [CNT_W-1:0]  conflict_cnt
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   // Wait counter reload: the last WAIT cycle is the one in which mem_rdata
   // becomes valid, MEM_LAT cycles after the ACCESS cycle.
   localparam logic [3:0] WAIT_LOAD = 4'(MEM_LAT - 1);

   logic [1:0]        state;
   logic [3:0]        wait_cnt;
   logic              last_grant;   // 1 = debug won last; CPU wins first tie
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              grant_dbg;    // winner if a grant happens this cycle
   logic              tie;

   // Round-robin pick: on a tie the port that did not win last time goes.
   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      tie       = cpu_req && dbg_req;
      grant_dbg = dbg_req;
      if (tie) grant_dbg = ~last_grant;
   end

   // Transaction FSM, field latches, read-data registers, contention counter.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         wait_cnt     <= '0;
         last_grant   <= 1'b1;
         gnt_dbg      <= 1'b0;
         lat_we       <= 1'b0;
         lat_addr     <= '0;
         lat_wdata    <= '0;
         cpu_rdata    <= '0;
         dbg_rdata    <= '0;
         conflict_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cpu_req || dbg_req) begin
                  gnt_dbg    <= grant_dbg;
                  last_grant <= grant_dbg;
                  lat_we     <= grant_dbg ? dbg_we    : cpu_we;
                  lat_addr   <= grant_dbg ? dbg_addr  : cpu_addr;
                  lat_wdata  <= grant_dbg ? dbg_wdata : cpu_wdata;
                  state      <= S_ACCESS;
                  if (tie && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + 1'b1;
               end
            end
            S_ACCESS: begin
               wait_cnt <= WAIT_LOAD;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               if (wait_cnt == '0) begin
                  // Writes still wait out the latency but leave rdata alone.
                  if (!lat_we) begin
                     if (gnt_dbg) dbg_rdata <= mem_rdata;
                     else         cpu_rdata <= mem_rdata;
                  end
                  state <= S_RESP;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            default: begin   // S_RESP
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Memory strobe and fields exist only during ACCESS; zero elsewhere.
   assign mem_en    = (state == S_ACCESS);
   assign mem_we    = mem_en && lat_we;
   assign mem_addr  = mem_en ? lat_addr  : '0;
   assign mem_wdata = mem_en ? lat_wdata : '0;

   // One-cycle completion pulse to the winner only.
   assign cpu_ready = (state == S_RESP) && !gnt_dbg;
   assign dbg_ready = (state == S_RESP) &&  gnt_dbg;

endmodule
